spi_master_multi: RTL
=====================

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 Parameter DATA_W, default 8, bits per transfer (legal range 4..32).
REQ-002 Parameter N_CS, default 4, number of chip-select lines (legal range 1..8).
REQ-003 Parameter CLK_DIV, default 4, clk cycles per SCLK half-period (legal minimum 2).
REQ-004 Port clk  input  1  system clock; all state updates on rising edge.
REQ-005 Port reset_n  input  1  asynchronous active-low reset.
REQ-006 Port start_i  input  1  transfer request, sampled each clk.
REQ-007 Port cpol_i  input  1  SCLK idle level, sampled at start acceptance.
REQ-008 Port cpha_i  input  1  clock phase, sampled at start acceptance.
REQ-009 Port lsb_first_i  input  1  bit order (1 = LSB first), sampled at start acceptance.
REQ-010 Port cs_sel_i  input  max(1,$clog2(N_CS))  target slave index, sampled at start acceptance.
REQ-011 Port tx_data_i  input  DATA_W  word to transmit, sampled at start acceptance.
REQ-012 Port rx_data_o  output  DATA_W  last received word.
REQ-013 Port busy_o  output  1  high from the cycle after acceptance until done_o.
REQ-014 Port done_o  output  1  single-cycle completion pulse.
REQ-015 Port miso_i  input  1  serial data from slave.
REQ-016 Port sclk_o  output  1  serial clock.
REQ-017 Port mosi_o  output  1  serial data to slave.
REQ-018 Port cs_n_o  output  N_CS  active-low chip selects.

Function
REQ-019 FSM states: IDLE, SETUP, XFER, HOLD; all outputs registered.
REQ-020 Accept: start_i=1 in IDLE latches cpol/cpha/lsb_first/cs_sel/tx_data; next cycle enters SETUP. start_i outside IDLE is ignored.
REQ-021 SETUP: CLK_DIV cycles; cs_n_o[cs_sel] low; mosi_o = first bit; sclk_o = cpol.
REQ-022 XFER: DATA_W SCLK periods, each 2*CLK_DIV clk cycles; sclk_o toggles every CLK_DIV cycles, ends at cpol level.
REQ-023 cpha=0: miso sampled on leading edge, mosi shifted on trailing edge; cpha=1: mosi shifted on leading edge, miso sampled on trailing edge.
REQ-024 Bit order: lsb_first=0 sends/receives MSB first; 1 sends/receives LSB first; rx word assembled in the same order.
REQ-025 HOLD: CLK_DIV cycles, cs still asserted, sclk_o = cpol; then all cs_n_o high, return to IDLE.
REQ-026 On HOLD->IDLE: rx_data_o updated and done_o=1 for exactly one cycle, busy_o falls same cycle.
REQ-027 Latency: start accepted at cycle 0 -> done_o at cycle 1 + CLK_DIV*(2*DATA_W+2) (73 for defaults).
REQ-028 Back-to-back: start_i high in the done_o cycle is accepted (IDLE); cs_n_o high at least 1 cycle between transfers.
REQ-029 cs_sel >= N_CS: transfer runs with full timing, all cs_n_o stay high.
REQ-030 In IDLE sclk_o tracks cpol_i (registered); mosi_o holds 0.
REQ-031 rx_data_o holds its value between transfers; unchanged by ignored starts.

Reset
REQ-032 reset_n low at any time, including mid-transfer: state IDLE, sclk_o=0, mosi_o=0, cs_n_o all 1, rx_data_o=0, busy_o=0, done_o=0, counters cleared; no done_o for aborted transfer.
REQ-033 First start accepted is the first clk edge with reset_n high and start_i high.

Structure
REQ-034 Package spi_pkg holds state enum spi_state_t and mode struct (cpol, cpha, lsb_first).
REQ-035 Sub-module spi_clk_gen: CLK_DIV counter producing lead/trail edge strobes, enabled only in XFER.
REQ-036 Single shift register for tx and rx, direction selected by latched lsb_first.

Verification
REQ-037 Mode 0, MSB first, tx=0xA5, miso loopback from mosi -> mosi bits 1,0,1,0,0,1,0,1; rx_data_o=0xA5; done_o at cycle 73.
REQ-038 Mode 3, LSB first, tx=0x3C, miso tied 1 -> sclk idles high, mosi bits 0,0,1,1,1,1,0,0; rx_data_o=0xFF.
REQ-039 cs_sel=2 then cs_sel=5 (N_CS=4) -> only cs_n_o[2] low in first; no cs low in second, done_o still at cycle 73.
REQ-040 start_i pulsed at cycle 20 of active transfer -> ignored; exactly one done_o; next start in done cycle begins new transfer.
REQ-041 reset_n low at cycle 30 of transfer -> outputs at reset values that cycle, no done_o, rx_data_o=0.
REQ-042 DATA_W=16, CLK_DIV=2, mode 1, tx=0x8001 loopback -> rx_data_o=0x8001, done_o at cycle 69.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding and the latched transfer mode.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period timer: strobes the last clk cycle of each half period,
// alternating between leading and trailing edges. Held cleared while disabled.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic lead,
  output logic trail
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          phase;
  logic          tick;

  assign tick  = en && (cnt == CW'(CLK_DIV - 1));
  assign lead  = tick && !phase;
  assign trail = tick && phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// SPI master with per-transfer mode, bit order and slave select.
// A single shift register carries both the outgoing and the incoming word.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int N_CS    = 4,
  parameter int CLK_DIV = 4,
  localparam int CSW    = (N_CS > 1) ? $clog2(N_CS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic [CSW-1:0]    cs_sel_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              busy_o,
  output logic              done_o,
  input  logic              miso_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic [N_CS-1:0]   cs_n_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_W);

  spi_state_t        state;
  spi_mode_t         mode;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shifted;
  logic              rx_bit;
  logic              shift_in;
  logic              lead;
  logic              trail;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_cnt;

  // Out-of-range selects leave every line deasserted.
  function automatic logic [N_CS-1:0] cs_decode(input logic [CSW-1:0] sel);
    logic [N_CS-1:0] res;
    res = '1;
    for (int i = 0; i < N_CS; i++)
      if (sel == CSW'(i)) res[i] = 1'b0;
    return res;
  endfunction

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (state == XFER),
    .lead   (lead),
    .trail  (trail)
  );

  // cpha=0 captures miso on the leading edge into rx_bit; cpha=1 takes it live on the trailing edge.
  always_comb begin
    shift_in = mode.cpha ? miso_i : rx_bit;
    shifted  = mode.lsb_first ? {shift_in, shreg[DATA_W-1:1]}
                              : {shreg[DATA_W-2:0], shift_in};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mode      <= '0;
      shreg     <= '0;
      rx_bit    <= 1'b0;
      cnt       <= '0;
      bit_cnt   <= '0;
      sclk_o    <= 1'b0;
      mosi_o    <= 1'b0;
      cs_n_o    <= '1;
      rx_data_o <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          sclk_o <= cpol_i;
          mosi_o <= 1'b0;
          if (start_i) begin
            mode    <= {cpol_i, cpha_i, lsb_first_i};
            shreg   <= tx_data_i;
            mosi_o  <= lsb_first_i ? tx_data_i[0] : tx_data_i[DATA_W-1];
            cs_n_o  <= cs_decode(cs_sel_i);
            cnt     <= '0;
            bit_cnt <= '0;
            busy_o  <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          sclk_o <= mode.cpol;
          if (cnt == CW'(CLK_DIV - 1)) begin
            cnt   <= '0;
            state <= XFER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        XFER: begin
          if (lead) begin
            sclk_o <= ~sclk_o;
            if (mode.cpha) mosi_o <= mode.lsb_first ? shreg[0] : shreg[DATA_W-1];
            else           rx_bit <= miso_i;
          end
          if (trail) begin
            sclk_o <= ~sclk_o;
            shreg  <= shifted;
            if (!mode.cpha) mosi_o <= mode.lsb_first ? shifted[0] : shifted[DATA_W-1];
            if (bit_cnt == BW'(DATA_W - 1)) begin
              bit_cnt <= '0;
              state   <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          sclk_o <= mode.cpol;
          if (cnt == CW'(CLK_DIV - 1)) begin
            cnt       <= '0;
            cs_n_o    <= '1;
            rx_data_o <= shreg;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            sclk_o    <= cpol_i;
            mosi_o    <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
